// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - shared dBUS arbiter for data walker, instruction walker and memory stage
// Single in-flight transaction; walkers have priority unless dmem has been starved.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dwalk_req,
  output dbus_resp_t dwalk_resp,
  input  dbus_req_t  iwalk_req,
  output dbus_resp_t iwalk_resp,
  input  dbus_req_t  dmem_req,
  output dbus_resp_t dmem_resp,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic [1:0] owner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_owner;
  logic [1:0]    w_winner;
  dbus_req_t     r_hold;
  dbus_req_t     w_win_req;
  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= 2'd0;
      r_hold   <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
      if (r_state == IDLE && w_winner != 2'd0) begin
        r_owner <= w_winner;
        r_hold  <= w_win_req;
      end else if (r_state == BUSY && dresp.data_ok) begin
        r_owner <= 2'd0;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_winner      = 2'd0;
    w_win_req     = '0;
    w_starve_next = r_starve;
    case (r_state)
      IDLE: begin
        // A saturated counter lets a waiting dmem jump both walkers.
        if (r_starve == LIMIT && dmem_req.valid) w_winner = 2'd3;
        else if (dwalk_req.valid)                w_winner = 2'd1;
        else if (iwalk_req.valid)                w_winner = 2'd2;
        else if (dmem_req.valid)                 w_winner = 2'd3;

        case (w_winner)
          2'd1:    w_win_req = dwalk_req;
          2'd2:    w_win_req = iwalk_req;
          2'd3:    w_win_req = dmem_req;
          default: w_win_req = '0;
        endcase

        if (w_winner != 2'd0) w_state_next = BUSY;

        if (w_winner == 2'd3 || !dmem_req.valid) w_starve_next = '0;
        else if (w_winner != 2'd0 && r_starve != LIMIT) w_starve_next = r_starve + CW'(1);
      end
      BUSY: begin
        if (dresp.data_ok) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    dreq       = '0;
    dwalk_resp = '0;
    iwalk_resp = '0;
    dmem_resp  = '0;
    if (r_state == BUSY) begin
      dreq = r_hold;
      case (r_owner)
        2'd1:    dwalk_resp = dresp;
        2'd2:    iwalk_resp = dresp;
        2'd3:    dmem_resp  = dresp;
        default: ;
      endcase
    end
  end

  assign owner = r_owner;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - scoreboard bench for dbus_arbiter
module tb_dbus_arbiter;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dwalk_req = '0;
  dbus_req_t  iwalk_req = '0;
  dbus_req_t  dmem_req = '0;
  dbus_resp_t dresp = '0;
  dbus_resp_t dwalk_resp, iwalk_resp, dmem_resp;
  dbus_req_t  dreq;
  logic [1:0] owner;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  dbus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .dwalk_req (dwalk_req),
    .dwalk_resp(dwalk_resp),
    .iwalk_req (iwalk_req),
    .iwalk_resp(iwalk_resp),
    .dmem_req  (dmem_req),
    .dmem_resp (dmem_resp),
    .dreq      (dreq),
    .dresp     (dresp),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic dbus_req_t mk_req(input logic v, input logic [31:0] a);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'd3;
    r.strobe = 8'hff;
    r.data   = {a, 32'h5a5a_0000};
    return r;
  endfunction

  function automatic logic [63:0] mk_data(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic dbus_resp_t pick(input logic [1:0] o);
    case (o)
      2'd1:    return dwalk_resp;
      2'd2:    return iwalk_resp;
      2'd3:    return dmem_resp;
      default: return '0;
    endcase
  endfunction

  function automatic logic others_nz(input logic [1:0] o);
    return (o != 2'd1 && |dwalk_resp) || (o != 2'd2 && |iwalk_resp) || (o != 2'd3 && |dmem_resp);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_owner"}, 64'(owner), 64'd0);
    chk({tag, "_dreq_valid"}, 64'(dreq.valid), 64'd0);
    chk({tag, "_resp_zero"}, 64'(others_nz(2'd0)), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_quiet("reset");
  endtask

  task automatic wait_grant();
    int n = 0;
    bit got = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      n++;
      if (dreq.valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("grant_timeout", 64'd0, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      return;
    end
    cur = sb.pop_front();
    chk("grant_lat", 64'(n), 64'd1);
    chk("grant_owner", 64'(owner), 64'(cur.owner));
    chk("grant_addr", 64'(dreq.addr), 64'(cur.addr));
    chk("grant_strobe", 64'(dreq.strobe), 64'hff);
  endtask

  task automatic complete(input int lat);
    dbus_resp_t r;
    repeat (lat) begin
      @(posedge clk);
      #1;
      chk("hold_addr", 64'(dreq.addr), 64'(cur.addr));
      chk("hold_owner", 64'(owner), 64'(cur.owner));
    end
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: mk_data(cur.addr)};
    #1;
    r = pick(cur.owner);
    chk("resp_data_ok", 64'(r.data_ok), 64'd1);
    chk("resp_data", r.data, mk_data(cur.addr));
    chk("resp_others", 64'(others_nz(cur.owner)), 64'd0);
    @(posedge clk);
    #1;
    dresp = '0;
    chk_quiet("bubble");
  endtask

  initial begin
    do_reset();

    // stray data_ok while idle with nothing pending
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hdead_beef};
    repeat (2) begin
      #1;
      chk_quiet("stray_ok");
      @(posedge clk);
    end
    #1;
    dresp = '0;

    // single dmem transaction
    dmem_req = mk_req(1'b1, 32'h8000_1000);
    sb.push_back('{owner: 2'd3, addr: 32'h8000_1000});
    wait_grant();
    complete(3);
    dmem_req = '0;

    // all three at once: fixed priority with one bubble each
    dwalk_req = mk_req(1'b1, 32'h0000_1100);
    iwalk_req = mk_req(1'b1, 32'h0000_2200);
    dmem_req  = mk_req(1'b1, 32'h0000_3300);
    sb.push_back('{owner: 2'd1, addr: 32'h0000_1100});
    sb.push_back('{owner: 2'd2, addr: 32'h0000_2200});
    sb.push_back('{owner: 2'd3, addr: 32'h0000_3300});
    wait_grant();
    complete(1);
    dwalk_req = '0;
    wait_grant();
    complete(0);
    iwalk_req = '0;
    wait_grant();
    complete(2);
    dmem_req = '0;

    // starvation: dmem wins the 5th arbitration, then walkers resume
    do_reset();
    dwalk_req = mk_req(1'b1, 32'h0000_4400);
    iwalk_req = mk_req(1'b1, 32'h0000_5500);
    dmem_req  = mk_req(1'b1, 32'h0000_6600);
    for (int i = 0; i < 4; i++) sb.push_back('{owner: 2'd1, addr: 32'h0000_4400});
    sb.push_back('{owner: 2'd3, addr: 32'h0000_6600});
    sb.push_back('{owner: 2'd1, addr: 32'h0000_4400});
    for (int i = 0; i < 6; i++) begin
      wait_grant();
      complete(1);
    end
    dwalk_req = '0;
    iwalk_req = '0;
    dmem_req  = '0;

    // iwalk changes its request mid-flight; dwalk arrives while busy
    iwalk_req = mk_req(1'b1, 32'h0000_7700);
    sb.push_back('{owner: 2'd2, addr: 32'h0000_7700});
    sb.push_back('{owner: 2'd1, addr: 32'h0000_8800});
    wait_grant();
    iwalk_req = mk_req(1'b0, 32'h0000_9900);
    dwalk_req = mk_req(1'b1, 32'h0000_8800);
    complete(3);
    wait_grant();
    complete(1);
    dwalk_req = '0;

    // reset in the middle of a transaction
    dmem_req = mk_req(1'b1, 32'h0000_aa00);
    sb.push_back('{owner: 2'd3, addr: 32'h0000_aa00});
    wait_grant();
    @(posedge clk);
    #1;
    reset = 1'b1;
    dmem_req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_quiet("mid_reset");
    dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1234};
    #1;
    chk("late_ok_dmem", 64'(dmem_resp.data_ok), 64'd0);
    @(posedge clk);
    #1;
    dresp = '0;
    chk_quiet("late_ok");
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive walker grants allowed while dmem waits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port dwalk_req  input  dbus_req_t  data-side page-walk request.
REQ-005 SHALL have port dwalk_resp  output  dbus_resp_t  response to the data walker.
REQ-006 SHALL have port iwalk_req  input  dbus_req_t  instruction-side page-walk request.
REQ-007 SHALL have port iwalk_resp  output  dbus_resp_t  response to the instruction walker.
REQ-008 SHALL have port dmem_req  input  dbus_req_t  load/store request from the memory stage.
REQ-009 SHALL have port dmem_resp  output  dbus_resp_t  response to the memory stage.
REQ-010 SHALL have port dreq  output  dbus_req_t  shared dBUS request.
REQ-011 SHALL have port dresp  input  dbus_resp_t  shared dBUS response.
REQ-012 SHALL have port owner  output  2  current grant: 0 none, 1 dwalk, 2 iwalk, 3 dmem.

Function
REQ-013 SHALL implement 2 states: IDLE (no owner) and BUSY (one owner, transaction in flight).
REQ-014 In IDLE, SHALL drive dreq.valid=0 and owner=0.
REQ-015 In IDLE with any requester valid, SHALL pick a winner combinationally and latch it on the clock edge. Normal priority: dwalk > iwalk > dmem.
REQ-016 On grant, SHALL capture the winner's full request (addr, size, strobe, data) into a holding register and enter BUSY.
REQ-017 In BUSY, SHALL drive dreq from the holding register with valid=1, unchanged every cycle until dresp.data_ok=1.
REQ-018 In BUSY, SHALL route dresp (data, addr_ok, data_ok) to the owner's response port only. Every other response port SHALL be all-zero.
REQ-019 In the cycle dresp.data_ok=1, SHALL return to IDLE on that edge. Exactly one idle cycle follows before the next grant, giving one bubble between back-to-back transactions.
REQ-020 Latency SHALL be: request valid in an IDLE cycle -> dreq.valid=1 on the next cycle. Owner data_ok is the same cycle as dresp.data_ok.
REQ-021 If the owner deasserts valid or changes its request during BUSY, the arbiter SHALL ignore the change. The captured transaction completes and its data_ok is still delivered to the owner.
REQ-022 Starvation counter, width $clog2(STARVE_LIMIT+1):
- increments on each grant to dwalk or iwalk while dmem_req.valid=1;
- clears on any dmem grant, and in any IDLE cycle with dmem_req.valid=0;
- saturates at STARVE_LIMIT.
REQ-023 When the counter equals STARVE_LIMIT and dmem_req.valid=1, dmem SHALL win the next arbitration regardless of walker requests.
REQ-024 Requesters valid only while BUSY SHALL be held off. Their response ports read zero, and they win no earlier than the next IDLE cycle.
REQ-025 dresp.data_ok arriving in IDLE SHALL be ignored: no response port asserts and no state change occurs.

Reset
REQ-026 On reset, SHALL enter IDLE with owner=0, dreq.valid=0, holding register zero, starvation counter zero, and all response ports zero, including reset asserted mid-transaction.
REQ-027 After reset deasserts, the first grant SHALL occur no earlier than the first IDLE cycle with a valid request.

Verification
REQ-028 dmem_req valid, addr=0x80001000, strobe=0xFF; dresp.data_ok after 3 cycles -> dreq.valid rises 1 cycle later with addr 0x80001000; dmem_resp.data_ok pulses once; owner=3 during BUSY.
REQ-029 dwalk, iwalk and dmem all valid in the same cycle -> grant order dwalk, iwalk, dmem, each separated by one IDLE bubble.
REQ-030 STARVE_LIMIT=4; walkers continuously valid; dmem valid throughout -> dmem granted on the 5th arbitration.
REQ-031 iwalk owner drops valid and changes addr 1 cycle after grant -> dreq.addr unchanged; iwalk_resp.data_ok still pulses with dresp.data.
REQ-032 Reset asserted during BUSY -> next cycle dreq.valid=0, owner=0. A later dresp.data_ok in IDLE produces no response pulse.
REQ-033 dresp.data_ok=1 while IDLE with no requests -> all response ports stay zero; owner stays 0.
